// File: rtl/router_local_port.sv
// Local-port endpoint between the DDMA and the router crossbar: an inject FIFO with packet
// framing toward the switch, and an unframed eject FIFO back toward the DDMA.
module router_local_port #(
  parameter int FLIT_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  input  logic [FLIT_WIDTH-1:0] data_i,
  output logic                  credit_o,
  output logic                  tx,
  output logic [FLIT_WIDTH-1:0] data_o,
  input  logic                  credit_i,
  output logic                  inj_valid,
  output logic [FLIT_WIDTH-1:0] inj_data,
  output logic                  inj_head,
  output logic                  inj_tail,
  output logic [15:0]           inj_dest,
  input  logic                  inj_ready,
  input  logic                  ej_valid,
  input  logic [FLIT_WIDTH-1:0] ej_data,
  output logic                  ej_ready,
  output logic [15:0]           inj_pkts,
  output logic                  err_o
);

  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH);

  localparam logic [1:0] ST_HEADER  = 2'd0;
  localparam logic [1:0] ST_SIZE    = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  logic [FLIT_WIDTH-1:0] r_injMem [BUFFER_DEPTH];
  logic [PTR_W-1:0]      r_injRd;
  logic [PTR_W-1:0]      r_injWr;
  logic [CNT_W-1:0]      r_injCount;

  logic [FLIT_WIDTH-1:0] r_ejMem [BUFFER_DEPTH];
  logic [PTR_W-1:0]      r_ejRd;
  logic [PTR_W-1:0]      r_ejWr;
  logic [CNT_W-1:0]      r_ejCount;

  logic [1:0]  r_state;
  logic [15:0] r_remaining;
  logic [15:0] r_injDest;
  logic [15:0] r_injPkts;
  logic        r_err;

  logic        w_injPush;
  logic        w_injPop;
  logic        w_ejPush;
  logic        w_ejPop;
  logic [15:0] w_injLow;

  // Credits are forced low while reset is held so the DDMA and switch cannot push.
  assign credit_o  = !reset && (r_injCount != FULL_CNT);
  assign ej_ready  = !reset && (r_ejCount != FULL_CNT);
  assign inj_valid = (r_injCount != '0);
  assign tx        = (r_ejCount != '0);
  assign inj_data  = r_injMem[r_injRd];
  assign data_o    = r_ejMem[r_ejRd];

  assign w_injPush = rx && credit_o;
  assign w_injPop  = inj_valid && inj_ready;
  assign w_ejPush  = ej_valid && ej_ready;
  assign w_ejPop   = tx && credit_i;
  assign w_injLow  = inj_data[15:0];

  assign inj_head = inj_valid && (r_state == ST_HEADER);
  assign inj_tail = inj_valid &&
                    (((r_state == ST_SIZE) && (w_injLow == 16'd0)) ||
                     ((r_state == ST_PAYLOAD) && (r_remaining == 16'd1)));

  assign inj_dest = r_injDest;
  assign inj_pkts = r_injPkts;
  assign err_o    = r_err;

  always_ff @(posedge clock) begin
    if (w_injPush) r_injMem[r_injWr] <= data_i;
    if (w_ejPush)  r_ejMem[r_ejWr]   <= ej_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_injRd    <= '0;
      r_injWr    <= '0;
      r_injCount <= '0;
    end else begin
      if (w_injPush) r_injWr <= r_injWr + PTR_W'(1);
      if (w_injPop)  r_injRd <= r_injRd + PTR_W'(1);
      case ({w_injPush, w_injPop})
        2'b10:   r_injCount <= r_injCount + CNT_W'(1);
        2'b01:   r_injCount <= r_injCount - CNT_W'(1);
        default: r_injCount <= r_injCount;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ejRd    <= '0;
      r_ejWr    <= '0;
      r_ejCount <= '0;
    end else begin
      if (w_ejPush) r_ejWr <= r_ejWr + PTR_W'(1);
      if (w_ejPop)  r_ejRd <= r_ejRd + PTR_W'(1);
      case ({w_ejPush, w_ejPop})
        2'b10:   r_ejCount <= r_ejCount + CNT_W'(1);
        2'b01:   r_ejCount <= r_ejCount - CNT_W'(1);
        default: r_ejCount <= r_ejCount;
      endcase
    end
  end

  // Framing only moves when the switch actually takes a flit; inj_tail decides packet end.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_HEADER;
      r_remaining <= 16'd0;
      r_injDest   <= 16'd0;
      r_injPkts   <= 16'd0;
    end else if (w_injPop) begin
      if (inj_tail) r_injPkts <= r_injPkts + 16'd1;
      case (r_state)
        ST_HEADER: begin
          r_injDest <= w_injLow;
          r_state   <= ST_SIZE;
        end
        ST_SIZE: begin
          r_remaining <= w_injLow;
          r_state     <= inj_tail ? ST_HEADER : ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          r_remaining <= r_remaining - 16'd1;
          if (inj_tail) r_state <= ST_HEADER;
        end
        default: r_state <= ST_HEADER;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 r_err <= 1'b0;
    else if (rx && !credit_o)  r_err <= 1'b1;
  end

endmodule

// File: tb/tb_router_local_port.sv
// Directed bench for router_local_port: a queue-based packet model checked every cycle,
// plus literal expectations for the key points of each scenario.
module tb_router_local_port;

  localparam int FW    = 32;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b0;
  logic [FW-1:0] data_i = '0;
  logic          credit_o;
  logic          tx;
  logic [FW-1:0] data_o;
  logic          credit_i = 1'b0;
  logic          inj_valid;
  logic [FW-1:0] inj_data;
  logic          inj_head;
  logic          inj_tail;
  logic [15:0]   inj_dest;
  logic          inj_ready = 1'b0;
  logic          ej_valid = 1'b0;
  logic [FW-1:0] ej_data = '0;
  logic          ej_ready;
  logic [15:0]   inj_pkts;
  logic          err_o;

  int total = 0;
  int bad   = 0;

  router_local_port #(.FLIT_WIDTH(FW), .BUFFER_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .rx(rx), .data_i(data_i), .credit_o(credit_o),
    .tx(tx), .data_o(data_o), .credit_i(credit_i), .inj_valid(inj_valid),
    .inj_data(inj_data), .inj_head(inj_head), .inj_tail(inj_tail), .inj_dest(inj_dest),
    .inj_ready(inj_ready), .ej_valid(ej_valid), .ej_data(ej_data), .ej_ready(ej_ready),
    .inj_pkts(inj_pkts), .err_o(err_o)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: flits kept in queues; framing tracked as position within the current packet.
  logic [FW-1:0] injQ[$];
  logic [FW-1:0] ejQ[$];
  int            mPos  = 0;
  int            mSize = 0;
  logic [15:0]   mDest = '0;
  logic [15:0]   mPkts = '0;
  logic          mErr  = 1'b0;

  always @(posedge clock) begin
    logic mCredit, mEjRdy, doPush, doPop, doEjPush, doEjPop, expTail;
    logic [FW-1:0] f;
    if (reset) begin
      injQ.delete();
      ejQ.delete();
      mPos = 0; mSize = 0; mDest = '0; mPkts = '0; mErr = 1'b0;
    end else begin
      mCredit  = injQ.size() < DEPTH;
      mEjRdy   = ejQ.size() < DEPTH;
      doPush   = rx && mCredit;
      doPop    = (injQ.size() > 0) && inj_ready;
      doEjPush = ej_valid && mEjRdy;
      doEjPop  = (ejQ.size() > 0) && credit_i;
      if (rx && !mCredit) mErr = 1'b1;
      if (doPop) begin
        f = injQ.pop_front();
        if (mPos == 0) begin
          mDest = f[15:0];
          mPos  = 1;
        end else if (mPos == 1) begin
          mSize = int'(f[15:0]);
          if (mSize == 0) begin mPkts = mPkts + 16'd1; mPos = 0; end
          else mPos = 2;
        end else if (mPos == mSize + 1) begin
          mPkts = mPkts + 16'd1;
          mPos  = 0;
        end else begin
          mPos++;
        end
      end
      if (doPush) injQ.push_back(data_i);
      if (doEjPop) void'(ejQ.pop_front());
      if (doEjPush) ejQ.push_back(ej_data);
    end
    #1;
    checkOutput("credit_o", credit_o, !reset && (injQ.size() < DEPTH));
    checkOutput("ej_ready", ej_ready, !reset && (ejQ.size() < DEPTH));
    checkOutput("inj_valid", inj_valid, injQ.size() > 0);
    checkOutput("tx", tx, ejQ.size() > 0);
    checkOutput("inj_dest", inj_dest, mDest);
    checkOutput("inj_pkts", inj_pkts, mPkts);
    checkOutput("err_o", err_o, mErr);
    if (injQ.size() > 0) begin
      f = injQ[0];
      expTail = ((mPos == 1) && (f[15:0] == 16'd0)) || ((mPos >= 2) && (mPos == mSize + 1));
      checkOutput("inj_data", inj_data, f);
      checkOutput("inj_head", inj_head, mPos == 0);
      checkOutput("inj_tail", inj_tail, expTail);
    end else begin
      checkOutput("inj_head_empty", inj_head, 1'b0);
      checkOutput("inj_tail_empty", inj_tail, 1'b0);
    end
    if (ejQ.size() > 0) checkOutput("data_o", data_o, ejQ[0]);
  end

  task automatic applyStimulus(input logic r, input logic [FW-1:0] d, input logic ir,
                               input logic ev, input logic [FW-1:0] ed, input logic ci);
    @(negedge clock);
    rx = r; data_i = d; inj_ready = ir; ej_valid = ev; ej_data = ed; credit_i = ci;
  endtask

  task automatic idle(input int n, input logic ir, input logic ci);
    repeat (n) applyStimulus(1'b0, '0, ir, 1'b0, '0, ci);
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  initial begin
    // Power-on reset and release
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    settle();
    checkOutput("rel_credit_o", credit_o, 1'b1);
    checkOutput("rel_ej_ready", ej_ready, 1'b1);
    checkOutput("rel_inj_pkts", inj_pkts, 16'h0000);

    // Basic 4-flit packet, switch always ready
    applyStimulus(1'b1, 32'h0003_0005, 1'b1, 1'b0, '0, 1'b0);
    settle();
    checkOutput("t2_hdr_data", inj_data, 32'h0003_0005);
    checkOutput("t2_hdr_head", inj_head, 1'b1);
    applyStimulus(1'b1, 32'h0000_0002, 1'b1, 1'b0, '0, 1'b0);
    settle();
    checkOutput("t2_dest", inj_dest, 16'h0005);
    checkOutput("t2_size_head", inj_head, 1'b0);
    applyStimulus(1'b1, 32'h0000_000A, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 32'h0000_000B, 1'b1, 1'b0, '0, 1'b0);
    settle();
    checkOutput("t2_tail_data", inj_data, 32'h0000_000B);
    checkOutput("t2_tail", inj_tail, 1'b1);
    idle(2, 1'b1, 1'b0);
    settle();
    checkOutput("t2_pkts", inj_pkts, 16'h0001);

    // Fill the inject FIFO while the switch stalls, then overflow
    applyStimulus(1'b1, 32'h0004_0003, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0002, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 32'h0000_00C1, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 32'h0000_00C2, 1'b0, 1'b0, '0, 1'b0);
    settle();
    checkOutput("t3_full_credit", credit_o, 1'b0);
    applyStimulus(1'b1, 32'h0000_0104, 1'b0, 1'b0, '0, 1'b0);
    settle();
    checkOutput("t3_err", err_o, 1'b1);
    checkOutput("t3_head_kept", inj_data, 32'h0004_0003);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    settle();
    checkOutput("t3_credit_back", credit_o, 1'b1);
    idle(4, 1'b1, 1'b0);
    settle();
    checkOutput("t3_pkts", inj_pkts, 16'h0002);
    checkOutput("t3_dest", inj_dest, 16'h0003);

    // Zero-payload packet
    applyStimulus(1'b1, 32'h0001_0007, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0000, 1'b1, 1'b0, '0, 1'b0);
    settle();
    checkOutput("t4_size_tail", inj_tail, 1'b1);
    idle(2, 1'b1, 1'b0);
    settle();
    checkOutput("t4_pkts", inj_pkts, 16'h0003);
    checkOutput("t4_dest", inj_dest, 16'h0007);

    // Eject path with DDMA back-pressure
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h11, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h22, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h33, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    settle();
    checkOutput("t5_tx", tx, 1'b1);
    checkOutput("t5_hold", data_o, 32'h11);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    settle();
    checkOutput("t5_next", data_o, 32'h22);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h44, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h55, 1'b0);
    settle();
    checkOutput("t5_full", ej_ready, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h66, 1'b0);
    idle(5, 1'b0, 1'b1);
    idle(1, 1'b0, 1'b0);
    settle();
    checkOutput("t5_drained", tx, 1'b0);

    // Reset in the middle of a 5-payload packet with an eject flit pending
    applyStimulus(1'b1, 32'h0005_0001, 1'b1, 1'b1, 32'h77, 1'b0);
    applyStimulus(1'b1, 32'h0000_0005, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    settle();
    checkOutput("t6_pre_tx", tx, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_credit", credit_o, 1'b0);
    checkOutput("t6_rst_ejrdy", ej_ready, 1'b0);
    checkOutput("t6_rst_tx", tx, 1'b0);
    checkOutput("t6_rst_injv", inj_valid, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    settle();
    checkOutput("t6_pkts0", inj_pkts, 16'h0000);
    checkOutput("t6_err0", err_o, 1'b0);
    checkOutput("t6_credit", credit_o, 1'b1);
    applyStimulus(1'b1, 32'h0002_0009, 1'b1, 1'b0, '0, 1'b0);
    settle();
    checkOutput("t6_head", inj_head, 1'b1);
    applyStimulus(1'b1, 32'h0000_0001, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 32'h0000_00D1, 1'b1, 1'b0, '0, 1'b0);
    settle();
    checkOutput("t6_tail", inj_tail, 1'b1);
    checkOutput("t6_tail_data", inj_data, 32'h0000_00D1);
    idle(2, 1'b1, 1'b0);
    settle();
    checkOutput("t6_pkts1", inj_pkts, 16'h0001);
    checkOutput("t6_dest", inj_dest, 16'h0009);

    idle(2, 1'b0, 1'b0);
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
